// File: rtl/mems_dac_spi.sv
// mems_dac_spi
//   Streams a sequence of 24-bit DAC command words from a ROM stage out over
//   a 3-wire SPI link (SCLK / SYNC_n / DIN). Addresses run
//   0 -> 1 -> 2 -> ... -> ADDR_LAST -> 2 -> ... while start is held high.
//   Words 0 and 1 (soft reset and Vref setup) are sent once per run only.
//
//   Optional feature: define MEMS_DAC_FRAME_CNT_EN to build the 32-bit
//   completed-frame counter. Without it, frame_cnt is tied to 0 and no
//   counter is built.
//
// Parameters
//   CLK_DIV     clk cycles per SCLK half-period (1..255)
//   ADDR_LAST   last sample address before wrapping back to 2 (2..65535)
//   GAP_CYCLES  clk cycles spent in the GAP state after each frame (1..15)
//
// Ports
//   clk         system clock, all logic on its rising edge
//   rst         synchronous active-high reset, overrides everything
//   start       level: high keeps the word sequence running
//   data[23:0]  ROM word for addr, valid one clk after addr changes
//   addr[15:0]  word address to the ROM stage
//   dac_sclk    SPI clock, idles high
//   dac_sync_n  SPI frame select, active low
//   dac_din     SPI data, MSB first, changes on SCLK rising edges
//   busy        high from leaving IDLE until returning to IDLE
//   frame_done  one-clk pulse on the clk where dac_sync_n returns high
//   frame_cnt   completed frame count (0 when the counter is not built)
//
// Frame timing: dac_sync_n is low for exactly 48*CLK_DIV clks. Between
// back-to-back frames it is high for GAP_CYCLES + 4 clks (GAP, NEXT, two
// WAIT clks for the ROM latency, LOAD).

module mems_dac_spi #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [15:0] ADDR_LAST  = 16'd65535,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] data,
    output logic [15:0] addr,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        SHIFT,
        GAP,
        NEXT
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic        wait_cnt;
    // Holds the 23 bits still to be sent; bit 23 goes straight to dac_din
    // on LOAD, so the shifter never needs to store it.
    logic [22:0] shreg;
    logic        half_end;
    logic        frame_end;

    // Last clk of an SCLK half-period, and the final rising edge of a frame.
    assign half_end  = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign frame_end = half_end && !dac_sclk && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            dac_sync_n <= 1'b1;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            wait_cnt   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    addr       <= '0;
                    dac_sync_n <= 1'b1;
                    dac_sclk   <= 1'b1;
                    dac_din    <= 1'b0;
                    wait_cnt   <= 1'b0;
                    if (start) begin
                        state <= WAIT;
                        busy  <= 1'b1;
                    end
                end

                // Two clks after addr settles: one for the ROM register,
                // one of margin before the word is captured in LOAD.
                WAIT: begin
                    if (wait_cnt) begin
                        state <= LOAD;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end

                LOAD: begin
                    shreg      <= data[22:0];
                    dac_din    <= data[23];
                    dac_sync_n <= 1'b0;
                    dac_sclk   <= 1'b1;
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    state      <= SHIFT;
                end

                SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        if (dac_sclk) begin
                            dac_sclk <= 1'b0;
                        end else begin
                            dac_sclk <= 1'b1;
                            if (frame_end) begin
                                // Last rise closes the frame in the same clk.
                                dac_sync_n <= 1'b1;
                                dac_din    <= 1'b0;
                                frame_done <= 1'b1;
                                gap_cnt    <= '0;
                                state      <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                dac_din <= shreg[22];
                                shreg   <= {shreg[21:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= NEXT;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                // The only place addr moves, so addr never changes while
                // dac_sync_n is low.
                NEXT: begin
                    wait_cnt <= 1'b0;
                    if (start) begin
                        state <= WAIT;
                        addr  <= (addr == ADDR_LAST) ? 16'd2 : addr + 16'd1;
                    end else begin
                        state <= IDLE;
                        addr  <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMS_DAC_FRAME_CNT_EN
    logic [31:0] frame_cnt_q;

    // Counts on the same clk that raises frame_done; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_mems_dac_spi.sv
// Testbench for mems_dac_spi with CLK_DIV=2, ADDR_LAST=5, GAP_CYCLES=3.
// A registered ROM model feeds data; a negedge monitor decodes SPI frames.
module tb_mems_dac_spi;

    localparam int CLK_DIV   = 2;
    localparam int GAP_CYC   = 3;
    localparam int FRAME_LEN = 48 * CLK_DIV;     // 96 clks with sync low
    localparam int HIGH_LEN  = GAP_CYC + 4;      // GAP + NEXT + 2xWAIT + LOAD
`ifdef MEMS_DAC_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] data;
    logic [15:0] addr;
    logic        dac_sclk;
    logic        dac_sync_n;
    logic        dac_din;
    logic        busy;
    logic        frame_done;
    logic [31:0] frame_cnt;

    logic [23:0] rom_q;
    logic        ovr;
    logic [23:0] ovr_val;

    int n_tests = 0;
    int n_fail  = 0;

    mems_dac_spi #(
        .CLK_DIV   (CLK_DIV),
        .ADDR_LAST (16'd5),
        .GAP_CYCLES(GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .data      (data),
        .addr      (addr),
        .dac_sclk  (dac_sclk),
        .dac_sync_n(dac_sync_n),
        .dac_din   (dac_din),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   return 24'h280001;
            16'd1:   return 24'h380001;
            default: return {8'h10, a};
        endcase
    endfunction

    assign data = ovr ? ovr_val : rom_q;

    initial forever begin
        @(posedge clk);
        rom_q <= rom_word(addr);
    end

    // ---------------- frame monitor ----------------
    logic [23:0] fr_word[$];
    int          fr_bits[$];
    int          fr_len[$];
    logic [15:0] fr_addr[$];
    int          gaps[$];
    logic [23:0] cur_word;
    int          cur_bits, cur_len, hi_len;
    logic [15:0] cur_addr;
    logic        prev_sync_n, prev_sclk, have_prev;
    int          done_cnt, done_at_rise, sclk_edges, addr_mid;

    task automatic clear_mon();
        fr_word.delete(); fr_bits.delete(); fr_len.delete();
        fr_addr.delete(); gaps.delete();
        cur_word = '0; cur_bits = 0; cur_len = 0; hi_len = 0; cur_addr = '0;
        have_prev = 1'b0; done_cnt = 0; done_at_rise = 0; addr_mid = 0;
        sclk_edges = 0;
        prev_sync_n = dac_sync_n; prev_sclk = dac_sclk;
    endtask

    initial forever begin
        @(negedge clk);
        if (prev_sync_n === 1'b1 && dac_sync_n === 1'b0) begin
            if (have_prev) gaps.push_back(hi_len);
            cur_len = 0; cur_bits = 0; cur_word = '0; cur_addr = addr;
        end
        if (prev_sync_n === 1'b0 && dac_sync_n === 1'b1) begin
            fr_word.push_back(cur_word);
            fr_bits.push_back(cur_bits);
            fr_len.push_back(cur_len);
            fr_addr.push_back(cur_addr);
            hi_len = 0;
            have_prev = 1'b1;
            if (frame_done === 1'b1) done_at_rise++;
        end
        if (dac_sync_n === 1'b0) begin
            cur_len++;
            if (prev_sclk === 1'b1 && dac_sclk === 1'b0) begin
                cur_word = {cur_word[22:0], dac_din};
                cur_bits++;
            end
            if (addr !== cur_addr) addr_mid++;
        end else begin
            hi_len++;
        end
        if (prev_sclk !== dac_sclk) sclk_edges++;
        if (frame_done === 1'b1) done_cnt++;
        if (busy === 1'b0) have_prev = 1'b0;
        prev_sync_n = dac_sync_n;
        prev_sclk   = dac_sclk;
    end

    // ---------------- checking helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (fr_word.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check_val("frames_reached", fr_word.size(), n);
    endtask

    task automatic wait_fall(input logic [15:0] a, input int b, input int budget);
        int   k   = 0;
        logic hit = 1'b0;
        while (!hit && k < budget) begin
            @(negedge clk); #1; k++;
            hit = (dac_sync_n === 1'b0) && (cur_addr == a) && (cur_bits == b);
        end
        check_val("fall_reached", hit, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check_val("busy_dropped", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int exp_seq1[11] = '{0, 1, 2, 3, 4, 5, 2, 3, 4, 5, 2};
    int exp_seq4[7]  = '{0, 1, 2, 3, 4, 5, 2};
    int base_edges;

    initial begin
        rst = 1'b1; start = 1'b0; ovr = 1'b0; ovr_val = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_addr",       addr,       16'd0);
        check_val("rst_sync_n",     dac_sync_n, 1'b1);
        check_val("rst_sclk",       dac_sclk,   1'b1);
        check_val("rst_din",        dac_din,    1'b0);
        check_val("rst_busy",       busy,       1'b0);
        check_val("rst_frame_done", frame_done, 1'b0);
        check_val("rst_frame_cnt",  frame_cnt,  32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        clear_mon();

        // Continuous run: 11 frames, address wrap 5 -> 2
        start = 1'b1;
        wait_frames(11, 3000);
        start = 1'b0;
        wait_idle(300);
        check_val("s1_first_word", fr_word[0], 24'h280001);
        for (int i = 0; i < 11 && i < fr_word.size(); i++) begin
            check_val($sformatf("s1_addr%0d", i), fr_addr[i], exp_seq1[i]);
            check_val($sformatf("s1_word%0d", i), fr_word[i], rom_word(16'(exp_seq1[i])));
            check_val($sformatf("s1_bits%0d", i), fr_bits[i], 24);
            check_val($sformatf("s1_len%0d", i),  fr_len[i],  FRAME_LEN);
        end
        check_val("s1_gap_count", gaps.size(), 10);
        foreach (gaps[i]) check_val($sformatf("s1_gap%0d", i), gaps[i], HIGH_LEN);
        check_val("s1_done_cnt",     done_cnt,     11);
        check_val("s1_done_at_rise", done_at_rise, 11);
        check_val("s1_addr_mid",     addr_mid,     0);
        check_val("s1_idle_addr",    addr,         16'd0);
        check_val("s1_frame_cnt",    frame_cnt,    FC_EN ? 32'd11 : 32'd0);

        // start dropped at SCLK fall #10 of the addr-3 frame
        @(negedge clk); #1;
        clear_mon();
        start = 1'b1;
        wait_fall(16'd3, 10, 1000);
        start = 1'b0;
        wait_idle(400);
        check_val("s2_frames", fr_word.size(), 4);
        if (fr_word.size() >= 4) begin
            check_val("s2_last_addr", fr_addr[3], 16'd3);
            check_val("s2_last_word", fr_word[3], rom_word(16'd3));
            check_val("s2_last_bits", fr_bits[3], 24);
            check_val("s2_last_len",  fr_len[3],  FRAME_LEN);
        end
        check_val("s2_idle_addr",   addr,       16'd0);
        check_val("s2_idle_sync_n", dac_sync_n, 1'b1);
        check_val("s2_done_cnt",    done_cnt,   4);

        // rst pulsed at SCLK fall #12
        @(negedge clk); #1;
        clear_mon();
        start = 1'b1;
        wait_fall(16'd0, 12, 400);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("s3_sync_n",     dac_sync_n, 1'b1);
        check_val("s3_sclk",       dac_sclk,   1'b1);
        check_val("s3_addr",       addr,       16'd0);
        check_val("s3_busy",       busy,       1'b0);
        check_val("s3_frame_done", frame_done, 1'b0);
        check_val("s3_frame_cnt",  frame_cnt,  32'd0);
        @(negedge clk); #1;
        base_edges = sclk_edges;
        repeat (60) @(negedge clk);
        #1;
        check_val("s3_no_sclk_edges", sclk_edges - base_edges, 0);
        check_val("s3_still_idle",    busy,                    1'b0);

        // Data change mid-SHIFT ignored; 7 frames for frame_cnt
        pulse_reset();
        @(negedge clk); #1;
        clear_mon();
        ovr = 1'b1; ovr_val = 24'h18ABCD;
        start = 1'b1;
        wait_fall(16'd0, 5, 400);
        ovr_val = 24'h000000;
        wait_frames(1, 400);
        ovr = 1'b0;
        wait_frames(7, 1500);
        start = 1'b0;
        wait_idle(300);
        if (fr_word.size() >= 7) begin
            check_val("s4_word0", fr_word[0], 24'h18ABCD);
            for (int i = 1; i < 7; i++) begin
                check_val($sformatf("s4_addr%0d", i), fr_addr[i], exp_seq4[i]);
                check_val($sformatf("s4_word%0d", i), fr_word[i], rom_word(16'(exp_seq4[i])));
            end
        end
        foreach (gaps[i]) check_val($sformatf("s4_gap%0d", i), gaps[i], HIGH_LEN);
        check_val("s4_frame_cnt", frame_cnt, FC_EN ? 32'd7 : 32'd0);
        check_val("s4_done_cnt",  done_cnt,  7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
